fifo_sync_fwft: RTL and testbench

- Parametrised single-clock FIFO, successor to the team's fixed 8x8 synchronous FIFO.
- Adds the following:
  - any DEPTH >= 2, not only powers of two;
  - a selectable first-word-fall-through (FWFT) read mode;
  - programmable almost-full and almost-empty flags;
  - overflow and underflow error pulses;
  - a synchronous flush input;
  - a count that can represent every level from 0 to DEPTH.
- Used as the general buffering primitive between datapath stages in one clock domain.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ram_sdp.sv | 48 ++++
 rtl/fifo_sync_fwft.sv | 164 ++++++++++++++++
 tb/tb_fifo_sync_fwft.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO family.
//   clog2()   : ceil(log2(n)), correct for non-power-of-two n, clog2(1) = 0
//   FIFO_STD  : registered read mode (q valid one cycle after an accepted read)
//   FIFO_FWFT : first-word-fall-through mode (head word presented on q)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// -----------------------------------------------------------------------------
// fifo_ram_sdp
// Simple dual-port RAM: one synchronous write port, one synchronous read port
// with a registered output. Memory contents are not reset; only the read
// output register is, so the FIFO presents q = 0 out of reset.
// Ports:
//   clk, rst_n   clock / async active-low reset (read register only)
//   wr_en        write strobe
//   wr_addr      write address, 0..DEPTH-1
//   wr_data      write data
//   rd_en        read strobe; rd_data holds when low
//   rd_addr      read address, 0..DEPTH-1
//   rd_data      registered read data
// -----------------------------------------------------------------------------
module fifo_ram_sdp
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    (* ramstyle = "M9K" *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_fwft.sv
// -----------------------------------------------------------------------------
// fifo_sync_fwft
// Parametrised single-clock FIFO with optional first-word-fall-through read.
// Any DEPTH >= 2; usedw spans 0..DEPTH. Full/empty are derived from usedw,
// never from pointer comparison.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   clr            synchronous flush, wins over wr_req and rd_req
//   wr_req, data   write request and data
//   rd_req         read request (FWFT: acknowledge of the word on q)
//   q              read data
//   full, empty    usedw == DEPTH / no word available
//   almost_full    usedw >= AF_LEVEL
//   almost_empty   usedw <= AE_LEVEL
//   usedw          words held (FWFT: includes the word on q)
//   overflow       one-cycle pulse after a write attempted while full
//   underflow      one-cycle pulse after a read attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_fwft
    import fifo_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 16,
    parameter  int FWFT     = FIFO_STD,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
    localparam int CW       = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] data,
    input  logic             rd_req,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    usedw,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = clog2(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_fwft: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_sync_fwft: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
        $error("fifo_sync_fwft: AE_LEVEL must be in 0..DEPTH-1");
    end
    if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
        $error("fifo_sync_fwft: FWFT must be 0 or 1");
    end

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    usedw_r;
    logic             wr_acc;
    logic             rd_acc;
    logic             ram_re;
    logic [PW-1:0]    ram_ra;
    logic [WIDTH-1:0] ram_q;

    assign full  = (usedw_r == CW'(DEPTH));
    assign empty = (usedw_r == '0);

    assign wr_acc     = !clr && wr_req && !full;
    assign rd_acc     = !clr && rd_req && !empty;
    assign rd_ptr_nxt = ptr_inc(rd_ptr);

    assign usedw        = usedw_r;
    assign almost_full  = (usedw_r >= CW'(AF_LEVEL));
    assign almost_empty = (usedw_r <= CW'(AE_LEVEL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw_r   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw_r   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_req && full;
            underflow <= rd_req && empty;
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({wr_acc, rd_acc})
                2'b10:   usedw_r <= usedw_r + CW'(1);
                2'b01:   usedw_r <= usedw_r - CW'(1);
                default: usedw_r <= usedw_r;
            endcase
        end
    end

    fifo_ram_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data),
        .rd_en   (ram_re),
        .rd_addr (ram_ra),
        .rd_data (ram_q)
    );

    if (FWFT == FIFO_STD) begin : g_std
        assign ram_re = rd_acc;
        assign ram_ra = rd_ptr;
        assign q      = ram_q;
    end else begin : g_fwft
        // rd_ptr addresses the head word shown on q. On a pop with at least two
        // words held, the next head is already in RAM and is fetched from
        // rd_ptr+1 on the same edge. When the new head is being written on that
        // very edge (FIFO empty, or one word popped while another arrives) the
        // RAM cannot return it yet, so it is captured in the bypass register.
        logic [WIDTH-1:0] byp_q;
        logic             byp_sel;
        logic             byp_load;

        assign byp_load = wr_acc &&
                          ((usedw_r == '0) || ((usedw_r == CW'(1)) && rd_acc));
        assign ram_re   = rd_acc && (usedw_r >= CW'(2));
        assign ram_ra   = rd_ptr_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                byp_q   <= '0;
                byp_sel <= 1'b1;
            end else if (byp_load) begin
                byp_q   <= data;
                byp_sel <= 1'b1;
            end else if (ram_re) begin
                byp_sel <= 1'b0;
            end
        end

        assign q = byp_sel ? byp_q : ram_q;
    end

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_fwft
// Drives one standard-mode and one FWFT-mode FIFO (DEPTH=5, AF=4, AE=1) with
// identical stimulus. A queue-based model predicts level, flags, error pulses
// and read data; a negedge process compares both DUTs every cycle, and the
// directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_fifo_sync_fwft;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         clr = 1'b0;
    logic         wr_req = 1'b0;
    logic [W-1:0] data = '0;
    logic         rd_req = 1'b0;

    logic [W-1:0]  s_q, f_q;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] s_usedw, f_usedw;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_fwft #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_req(wr_req), .data(data),
        .rd_req(rd_req), .q(s_q), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .usedw(s_usedw),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_sync_fwft #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_req(wr_req), .data(data),
        .rd_req(rd_req), .q(f_q), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .usedw(f_usedw),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] mq[$];
    logic [W-1:0] exp_std_q = '0;
    bit           exp_ovf = 1'b0;
    bit           exp_unf = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit w_ok;
        bit r_ok;
        if (!rst_n) begin
            mq.delete();
            exp_std_q <= '0;
            exp_ovf   <= 1'b0;
            exp_unf   <= 1'b0;
        end else if (clr) begin
            mq.delete();
            exp_ovf <= 1'b0;
            exp_unf <= 1'b0;
        end else begin
            w_ok = wr_req && (mq.size() < D);
            r_ok = rd_req && (mq.size() > 0);
            exp_ovf <= wr_req && (mq.size() == D);
            exp_unf <= rd_req && (mq.size() == 0);
            if (r_ok) begin
                exp_std_q <= mq[0];
                void'(mq.pop_front());
            end
            if (w_ok) mq.push_back(data);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("std.usedw", 32'(s_usedw), 32'(mq.size()));
            chk("std.full",  32'(s_full),  32'(mq.size() == D));
            chk("std.empty", 32'(s_empty), 32'(mq.size() == 0));
            chk("std.af",    32'(s_af),    32'(mq.size() >= AF));
            chk("std.ae",    32'(s_ae),    32'(mq.size() <= AE));
            chk("std.ovf",   32'(s_ovf),   32'(exp_ovf));
            chk("std.unf",   32'(s_unf),   32'(exp_unf));
            chk("std.q",     32'(s_q),     32'(exp_std_q));
            chk("fwft.usedw", 32'(f_usedw), 32'(mq.size()));
            chk("fwft.full",  32'(f_full),  32'(mq.size() == D));
            chk("fwft.empty", 32'(f_empty), 32'(mq.size() == 0));
            chk("fwft.af",    32'(f_af),    32'(mq.size() >= AF));
            chk("fwft.ae",    32'(f_ae),    32'(mq.size() <= AE));
            chk("fwft.ovf",   32'(f_ovf),   32'(exp_ovf));
            chk("fwft.unf",   32'(f_unf),   32'(exp_unf));
            if (mq.size() > 0) chk("fwft.q", 32'(f_q), 32'(mq[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit w, input logic [W-1:0] d, input bit r, input bit c);
        wr_req = w;
        data   = d;
        rd_req = r;
        clr    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rst.s_usedw"}, 32'(s_usedw), 0);
        chk({tag, ".rst.s_q"},     32'(s_q),     0);
        chk({tag, ".rst.s_empty"}, 32'(s_empty), 1);
        chk({tag, ".rst.s_full"},  32'(s_full),  0);
        chk({tag, ".rst.s_ae"},    32'(s_ae),    1);
        chk({tag, ".rst.s_af"},    32'(s_af),    0);
        chk({tag, ".rst.s_ovf"},   32'(s_ovf),   0);
        chk({tag, ".rst.s_unf"},   32'(s_unf),   0);
        chk({tag, ".rst.f_usedw"}, 32'(f_usedw), 0);
        chk({tag, ".rst.f_q"},     32'(f_q),     0);
        chk({tag, ".rst.f_empty"}, 32'(f_empty), 1);
        chk({tag, ".rst.f_ae"},    32'(f_ae),    1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("init");
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // 1: fill, overflow, drain
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        chk("t1.full", 32'(s_full), 1);
        chk("t1.usedw", 32'(s_usedw), 5);
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        chk("t1.ovf", 32'(s_ovf), 1);
        chk("t1.usedw_ovf", 32'(s_usedw), 5);
        idle();
        chk("t1.ovf_clear", 32'(s_ovf), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("t1.q", 32'(s_q), 32'(8'h11 + i));
        end
        chk("t1.empty", 32'(s_empty), 1);

        // 2: wrap
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
        chk("t2.fwft_head", 32'(f_q), 32'h31);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t2.q_last", 32'(s_q), 32'h35);
        chk("t2.usedw", 32'(s_usedw), 0);

        // 3: simultaneous read/write
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
            chk("t3.q", 32'(s_q), (i < 3) ? 32'(8'h41 + i) : 32'(8'h50 + i - 3));
        end
        chk("t3.usedw", 32'(s_usedw), 3);
        cyc(1'b1, 8'h60, 1'b0, 1'b0);
        cyc(1'b1, 8'h61, 1'b0, 1'b0);
        cyc(1'b1, 8'h62, 1'b1, 1'b0);
        chk("t3.full_usedw", 32'(s_usedw), 4);
        chk("t3.full_ovf", 32'(s_ovf), 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t3.q_drain", 32'(s_q), 32'h61);

        // 4: FWFT bypass from empty
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t4.fwft_q", 32'(f_q), 32'hA5);
        chk("t4.fwft_empty", 32'(f_empty), 0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t4.fwft_empty2", 32'(f_empty), 1);
        chk("t4.fwft_usedw", 32'(f_usedw), 0);

        // 5: almost flags
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, 8'(8'h70 + k), 1'b0, 1'b0);
            chk("t5.ae", 32'(s_ae), (k == 1) ? 1 : 0);
            chk("t5.af", 32'(s_af), (k >= 4) ? 1 : 0);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // 6: flush with write, underflow
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("t6.usedw", 32'(s_usedw), 0);
        chk("t6.empty", 32'(s_empty), 1);
        chk("t6.q_kept", 32'(s_q), 32'h72);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t6.unf", 32'(s_unf), 1);
        chk("t6.fwft_unf", 32'(f_unf), 1);
        chk("t6.usedw2", 32'(s_usedw), 0);

        // random traffic, bias alternating toward filling and draining
        for (int i = 0; i < 3000; i++) begin
            int pw;
            pw = ((i / 200) % 2 == 0) ? 70 : 30;
            cyc(($urandom_range(0, 99) < pw), 8'($urandom),
                ($urandom_range(0, 99) < (100 - pw)), ($urandom_range(0, 99) < 2));
        end

        // mid-burst asynchronous reset
        idle();
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        #1 chk_reset_vals("mid");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        idle();
        chk("end.usedw", 32'(s_usedw), 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
